// File: rtl/cesel_sched_if.sv
// Bundle of request, response, key and core-side signals for the CESEL scheduler.
// The scheduler connects through the slave modport; the requesters, response
// consumer and crypto core together form the master side.
interface cesel_sched_if #(
  parameter int DATA_W = 128
);
  logic              key_we;
  logic [DATA_W-1:0] key_wdata;
  logic              req0_valid;
  logic              req1_valid;
  logic [DATA_W-1:0] req0_pt;
  logic [DATA_W-1:0] req1_pt;
  logic              req0_ready;
  logic              req1_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_ct;
  logic              rsp_timeout;
  logic              core_start;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_pt;
  logic              core_busy;
  logic [DATA_W-1:0] core_ct;
  logic              sched_busy;

  modport slave (
    input  key_we, key_wdata, req0_valid, req1_valid, req0_pt, req1_pt,
           rsp_ready, core_busy, core_ct,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ct, rsp_timeout,
           core_start, core_key, core_pt, sched_busy
  );

  modport master (
    output key_we, key_wdata, req0_valid, req1_valid, req0_pt, req1_pt,
           rsp_ready, core_busy, core_ct,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ct, rsp_timeout,
           core_start, core_key, core_pt, sched_busy
  );
endinterface

// File: rtl/cesel_sched.sv
// Round-robin two-port scheduler and sequencer for the CESEL crypto core.
// Owns the shared key, issues one start pulse per accepted request, follows
// the core's busy rise and fall, and returns the ciphertext (or a watchdog
// timeout) on a single response channel.
module cesel_sched #(
  parameter int DATA_W     = 128,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic         clk,
  input logic         resetn,
  cesel_sched_if.slave bus
);

  localparam int CNT_MAX = (START_WAIT > TIMEOUT) ? START_WAIT : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SW_LIM = CNT_W'(START_WAIT);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

  state_t           state;
  logic             prio;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             idle;
  logic             accept;

  // Arbitration: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    grant = prio;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = 1'b1;
    end
  end

  assign idle           = (state == IDLE);
  assign bus.req0_ready = idle && bus.req0_valid && !grant;
  assign bus.req1_ready = idle && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign bus.sched_busy = !idle;

  // Sequencer FSM: accept, start pulse, wait for busy high then low, respond.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      prio            <= 1'b0;
      cnt             <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.core_start  <= 1'b0;
      bus.rsp_ct      <= '0;
      bus.core_pt     <= '0;
      bus.core_key    <= '0;
    end else begin
      bus.core_start <= 1'b0;
      case (state)
        IDLE: begin
          // Key only changes between operations so the core sees a stable key.
          if (bus.key_we) begin
            bus.core_key <= bus.key_wdata;
          end
          if (accept) begin
            bus.core_pt    <= grant ? bus.req1_pt : bus.req0_pt;
            bus.rsp_id     <= grant;
            prio           <= !grant;
            bus.core_start <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          // Busy is tested before the limit, so a rise on the last allowed
          // cycle still counts as a live core.
          if (bus.core_busy) begin
            cnt   <= '0;
            state <= WAIT_LO;
          end else if (cnt >= SW_LIM) begin
            bus.rsp_ct      <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!bus.core_busy) begin
            bus.rsp_ct      <= bus.core_ct;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (cnt >= TO_LIM) begin
            bus.rsp_ct      <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // Returning to IDLE costs a cycle; no accept overlaps the handshake.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cesel_sched.sv
// Directed plus randomized bench for cesel_sched. Each operation's response
// cycle, id, ciphertext and timeout flag are predicted from the core stub's
// busy-delay/busy-length using the scheduler's timing rules.
module tb_cesel_sched;

  localparam int W  = 128;
  localparam int SW = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         resetn;
  int           checks   = 0;
  int           failures = 0;
  logic         prio_m;
  logic [W-1:0] key_m;

  cesel_sched_if #(.DATA_W(W)) bus ();

  cesel_sched #(
    .DATA_W    (W),
    .START_WAIT(SW),
    .TIMEOUT   (TO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "time limit");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_reset(input string tag);
    chk1({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk1({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    chk1({tag, "_rsp_id"}, bus.rsp_id, 1'b0);
    chk1({tag, "_core_start"}, bus.core_start, 1'b0);
    chk1({tag, "_sched_busy"}, bus.sched_busy, 1'b0);
    chk1({tag, "_ready0"}, bus.req0_ready, 1'b0);
    chk1({tag, "_ready1"}, bus.req1_ready, 1'b0);
    chkw({tag, "_rsp_ct"}, bus.rsp_ct, '0);
    chkw({tag, "_core_pt"}, bus.core_pt, '0);
    chkw({tag, "_core_key"}, bus.core_key, '0);
  endtask

  task automatic key_write(input logic [W-1:0] k);
    bus.key_we    = 1'b1;
    bus.key_wdata = k;
    @(negedge clk);
    bus.key_we = 1'b0;
    key_m      = k;
    chkw("key_write", bus.core_key, key_m);
  endtask

  // One operation, started at the negedge of an IDLE cycle. The core stub
  // raises busy d cycles after the start pulse and holds it for h cycles.
  task automatic op(input logic v0, input logic v1,
                    input logic [W-1:0] pt0, input logic [W-1:0] pt1,
                    input logic [W-1:0] ct, input int d, input int h,
                    input int rdly, input int kwe_rel, input int rst_rel,
                    input bit keep);
    logic         g;
    logic         exp_to;
    logic [W-1:0] exp_ct;
    logic [W-1:0] exp_pt;
    int           exp_rel;
    bit           was_reset;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_pt    = pt0;
    bus.req1_pt    = pt1;
    bus.core_ct    = ct;
    bus.core_busy  = 1'b0;
    bus.rsp_ready  = 1'b0;
    bus.key_we     = 1'b0;
    #1;
    g = (v0 && !v1) ? 1'b0 : ((v1 && !v0) ? 1'b1 : prio_m);
    chk1("accept_ready0", bus.req0_ready, v0 && !g);
    chk1("accept_ready1", bus.req1_ready, v1 && g);
    chk1("accept_idle", bus.sched_busy, 1'b0);
    prio_m = !g;
    exp_pt = g ? pt1 : pt0;
    if (d - 1 > SW) begin
      exp_to = 1'b1; exp_ct = '0; exp_rel = 3 + SW;
    end else if (h - 1 > TO) begin
      exp_to = 1'b1; exp_ct = '0; exp_rel = 3 + d + TO;
    end else begin
      exp_to = 1'b0; exp_ct = ct; exp_rel = 2 + d + h;
    end
    was_reset = 1'b0;
    for (int rel = 1; rel <= exp_rel + rdly; rel++) begin
      @(negedge clk);
      if (rst_rel != 0 && rel == rst_rel + 1) begin
        chk_reset("midrst");
        resetn    = 1'b1;
        prio_m    = 1'b0;
        key_m     = '0;
        was_reset = 1'b1;
        break;
      end
      chk1("core_start", bus.core_start, rel == 1);
      chk1("sched_busy", bus.sched_busy, 1'b1);
      chk1("busy_ready0", bus.req0_ready, 1'b0);
      chk1("busy_ready1", bus.req1_ready, 1'b0);
      chkw("core_pt", bus.core_pt, exp_pt);
      chkw("core_key", bus.core_key, key_m);
      chk1("rsp_valid", bus.rsp_valid, rel >= exp_rel);
      if (rel >= exp_rel) begin
        chk1("rsp_id", bus.rsp_id, g);
        chk1("rsp_timeout", bus.rsp_timeout, exp_to);
        chkw("rsp_ct", bus.rsp_ct, exp_ct);
      end
      if (!keep) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      bus.core_busy = (rel >= 1 + d) && (rel <= d + h);
      bus.rsp_ready = (rel >= exp_rel + rdly);
      bus.key_we    = (rel == kwe_rel);
      if (rel == kwe_rel) bus.key_wdata = '1;
      if (rel == rst_rel) resetn = 1'b0;
    end
    if (!was_reset) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.key_we    = 1'b0;
      chk1("idle_after", bus.sched_busy, 1'b0);
      chk1("idle_rsp_valid", bus.rsp_valid, 1'b0);
    end
  endtask

  // Linear sequence of directed steps followed by a randomized run.
  initial begin
    logic         v0;
    logic         v1;
    logic [W-1:0] dead;
    resetn         = 1'b0;
    bus.key_we     = 1'b0;
    bus.key_wdata  = '0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_pt    = '0;
    bus.req1_pt    = '0;
    bus.rsp_ready  = 1'b0;
    bus.core_busy  = 1'b0;
    bus.core_ct    = '0;
    prio_m         = 1'b0;
    key_m          = '0;
    dead           = {4{32'hdeadbeef}};
    repeat (2) @(negedge clk);
    chk_reset("reset");
    resetn = 1'b1;
    @(negedge clk);

    key_write(128'h00112233445566778899aabbccddeeff);
    op(1'b1, 1'b0, 128'h123456789abcdef0123456789abcdef0, rnd128(), dead,
       1, 1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1, 1, 0, 0, 0, 1'b1);
    end

    op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), 100, 1, 3, 0, 0, 1'b0);
    op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1, 1000, 0, 0, 0, 1'b0);
    op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 5, 2, 1, 0, 0, 1'b0);
    op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 6, 2, 0, 0, 0, 1'b0);
    op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 2, 17, 0, 0, 0, 1'b0);
    op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), 2, 18, 2, 0, 0, 1'b0);

    op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1, 5, 0, 4, 0, 1'b0);
    key_write('1);

    for (int i = 0; i < 20; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      op(v0, v1, rnd128(), rnd128(), rnd128(), $urandom_range(1, 7),
         $urandom_range(1, 20), $urandom_range(0, 3), 0, 0, 1'b0);
    end

    op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), 1, 1000, 0, 0, 6, 1'b0);
    op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1, 1, 0, 0, 0, 1'b0);
    op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 2, 3, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
